// File: rtl/leaf_tx_pkg.sv
// rtl/leaf_tx_pkg.sv - Packet layout constants and packet type for the leaf transmit packetizer
package leaf_tx_pkg;

    localparam int DEF_PAYLOAD_BITS  = 32;
    localparam int DEF_NUM_LEAF_BITS = 5;
    localparam int DEF_NUM_PORT_BITS = 4;
    localparam int DEF_NUM_ADDR_BITS = 7;
    localparam int DEF_PACKET_BITS   = 1 + DEF_NUM_LEAF_BITS + DEF_NUM_PORT_BITS
                                       + DEF_NUM_ADDR_BITS + DEF_PAYLOAD_BITS;

    // Field offsets, payload in the LSBs and the valid flag in the MSB
    localparam int PAYLOAD_LSB = 0;
    localparam int SEQ_LSB     = PAYLOAD_LSB + DEF_PAYLOAD_BITS;
    localparam int PORT_LSB    = SEQ_LSB + DEF_NUM_ADDR_BITS;
    localparam int LEAF_LSB    = PORT_LSB + DEF_NUM_PORT_BITS;
    localparam int VALID_BIT   = LEAF_LSB + DEF_NUM_LEAF_BITS;

    typedef struct packed {
        logic                         valid;
        logic [DEF_NUM_LEAF_BITS-1:0] leaf;
        logic [DEF_NUM_PORT_BITS-1:0] port;
        logic [DEF_NUM_ADDR_BITS-1:0] seq;
        logic [DEF_PAYLOAD_BITS-1:0]  payload;
    } packet_t;

endpackage

// File: rtl/leaf_tx_fifo.sv
// rtl/leaf_tx_fifo.sv - Single-clock per-port buffer with full/empty flags and occupancy count
module leaf_tx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_wr && !do_rd) begin
                count <= count + (AW+1)'(1);
            end else if (!do_wr && do_rd) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/leaf_tx_packetizer.sv
// rtl/leaf_tx_packetizer.sv - Credit-gated round-robin packer of user output streams into BFT packets
module leaf_tx_packetizer
    import leaf_tx_pkg::*;
#(
    parameter int PACKET_BITS           = DEF_PACKET_BITS,
    parameter int PAYLOAD_BITS          = DEF_PAYLOAD_BITS,
    parameter int NUM_LEAF_BITS         = DEF_NUM_LEAF_BITS,
    parameter int NUM_PORT_BITS         = DEF_NUM_PORT_BITS,
    parameter int NUM_ADDR_BITS         = DEF_NUM_ADDR_BITS,
    parameter int NUM_OUT_PORTS         = 7,
    parameter int FIFO_DEPTH            = 4,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    parameter int MAX_CREDIT            = 128
) (
    input  logic                                    clk_400,
    input  logic                                    reset_n_400,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_user2tx,
    input  logic [NUM_OUT_PORTS-1:0]                vld_user2tx,
    output logic [NUM_OUT_PORTS-1:0]                ack_tx2user,
    input  logic                                    cfg_we,
    input  logic [NUM_PORT_BITS-1:0]                cfg_port,
    input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0]  cfg_dest,
    input  logic                                    upd_vld,
    input  logic [NUM_PORT_BITS-1:0]                upd_port,
    input  logic                                    resend,
    output logic [PACKET_BITS-1:0]                  dout_tx2bft,
    input  logic                                    dout_rdy
);
    localparam int DEST_BITS = NUM_LEAF_BITS + NUM_PORT_BITS;
    localparam int CW        = $clog2(MAX_CREDIT + FREESPACE_UPDATE_SIZE + 1);
    localparam int VLD       = PACKET_BITS - 1;

    logic [PAYLOAD_BITS-1:0]  fifo_data [NUM_OUT_PORTS];
    logic [NUM_OUT_PORTS-1:0] fifo_full;
    logic [NUM_OUT_PORTS-1:0] fifo_empty;
    logic [NUM_OUT_PORTS-1:0] pop;
    logic [NUM_OUT_PORTS-1:0] eligible;
    logic [NUM_OUT_PORTS-1:0] route_vld;
    logic [DEST_BITS-1:0]     route [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] seq [NUM_OUT_PORTS];
    logic [CW-1:0]            credit [NUM_OUT_PORTS];
    logic [CW-1:0]            credit_next [NUM_OUT_PORTS];
    logic [CW-1:0]            credit_sum;

    logic [NUM_PORT_BITS-1:0] rr_start;
    logic [NUM_PORT_BITS-1:0] hi_idx;
    logic [NUM_PORT_BITS-1:0] lo_idx;
    logic [NUM_PORT_BITS-1:0] grant_idx;
    logic                     hi_any;
    logic                     lo_any;
    logic                     grant_any;
    logic                     load;
    logic                     send;

    logic [DEST_BITS-1:0]     sel_route;
    logic [NUM_ADDR_BITS-1:0] sel_seq;
    logic [PAYLOAD_BITS-1:0]  sel_payload;
    logic [PACKET_BITS-1:0]   grant_pkt;
    logic [PACKET_BITS-1:0]   out_reg;

    for (genvar k = 0; k < NUM_OUT_PORTS; k++) begin : g_port
        assign ack_tx2user[k] = vld_user2tx[k] & ~fifo_full[k];
        assign eligible[k]    = ~fifo_empty[k] & (credit[k] != '0) & route_vld[k];
        assign pop[k]         = send & (grant_idx == NUM_PORT_BITS'(k));

        leaf_tx_fifo #(
            .WIDTH(PAYLOAD_BITS),
            .DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk_400),
            .rst_n   (reset_n_400),
            .wr_en   (ack_tx2user[k]),
            .wr_data (din_user2tx[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .rd_en   (pop[k]),
            .rd_data (fifo_data[k]),
            .full    (fifo_full[k]),
            .empty   (fifo_empty[k])
        );
    end

    // Lowest eligible port at or above rr_start wins; otherwise wrap to the lowest eligible overall
    always_comb begin
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int k = NUM_OUT_PORTS - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                lo_any = 1'b1;
                lo_idx = NUM_PORT_BITS'(k);
                if (NUM_PORT_BITS'(k) >= rr_start) begin
                    hi_any = 1'b1;
                    hi_idx = NUM_PORT_BITS'(k);
                end
            end
        end
        grant_any = lo_any;
        grant_idx = hi_any ? hi_idx : lo_idx;
    end

    always_comb begin
        sel_route   = '0;
        sel_seq     = '0;
        sel_payload = '0;
        for (int k = 0; k < NUM_OUT_PORTS; k++) begin
            if (NUM_PORT_BITS'(k) == grant_idx) begin
                sel_route   = route[k];
                sel_seq     = seq[k];
                sel_payload = fifo_data[k];
            end
        end
    end

    assign grant_pkt   = {1'b1, sel_route, sel_seq, sel_payload};
    assign load        = ~resend & (~out_reg[VLD] | dout_rdy);
    assign send        = load & grant_any;
    assign dout_tx2bft = resend ? '0 : out_reg;

    always_ff @(posedge clk_400 or negedge reset_n_400) begin
        if (!reset_n_400) begin
            out_reg  <= '0;
            rr_start <= '0;
        end else if (load) begin
            out_reg <= grant_any ? grant_pkt : '0;
            if (grant_any) begin
                rr_start <= (grant_idx == NUM_PORT_BITS'(NUM_OUT_PORTS - 1)) ? '0
                                                                             : grant_idx + NUM_PORT_BITS'(1);
            end
        end
    end

    // An update and a send in the same cycle net out before saturation
    always_comb begin
        credit_sum = '0;
        for (int k = 0; k < NUM_OUT_PORTS; k++) begin
            credit_sum = credit[k];
            if (upd_vld && upd_port == NUM_PORT_BITS'(k + 1)) begin
                credit_sum = credit_sum + CW'(FREESPACE_UPDATE_SIZE);
            end
            if (pop[k]) begin
                credit_sum = credit_sum - CW'(1);
            end
            credit_next[k] = (credit_sum > CW'(MAX_CREDIT)) ? CW'(MAX_CREDIT) : credit_sum;
        end
    end

    always_ff @(posedge clk_400 or negedge reset_n_400) begin
        if (!reset_n_400) begin
            route_vld <= '0;
            for (int k = 0; k < NUM_OUT_PORTS; k++) begin
                credit[k] <= '0;
                seq[k]    <= '0;
                route[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_OUT_PORTS; k++) begin
                credit[k] <= credit_next[k];
                if (pop[k]) begin
                    seq[k] <= seq[k] + NUM_ADDR_BITS'(1);
                end
                if (cfg_we && cfg_port == NUM_PORT_BITS'(k + 1)) begin
                    route[k]     <= cfg_dest;
                    route_vld[k] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_leaf_tx_packetizer.sv
// tb/tb_leaf_tx_packetizer.sv - Directed self-checking bench for leaf_tx_packetizer
module tb_leaf_tx_packetizer;
    import leaf_tx_pkg::*;

    localparam int N   = 7;
    localparam int PW  = 32;
    localparam int PKB = 49;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*PW-1:0] din;
    logic [N-1:0]   vld;
    logic [N-1:0]   ack;
    logic           cfg_we;
    logic [3:0]     cfg_port;
    logic [8:0]     cfg_dest;
    logic           upd_vld;
    logic [3:0]     upd_port;
    logic           resend;
    logic [PKB-1:0] dout;
    logic           dout_rdy;

    int checks = 0;
    int errors = 0;
    logic [PKB-1:0] rxq [$];

    always #5 clk = ~clk;

    leaf_tx_packetizer u_dut (
        .clk_400     (clk),
        .reset_n_400 (rst_n),
        .din_user2tx (din),
        .vld_user2tx (vld),
        .ack_tx2user (ack),
        .cfg_we      (cfg_we),
        .cfg_port    (cfg_port),
        .cfg_dest    (cfg_dest),
        .upd_vld     (upd_vld),
        .upd_port    (upd_port),
        .resend      (resend),
        .dout_tx2bft (dout),
        .dout_rdy    (dout_rdy)
    );

    always @(negedge clk) begin
        if (rst_n && dout[VALID_BIT] && dout_rdy) rxq.push_back(dout);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [PKB-1:0] pkt(input int leaf, input int port, input int sq, input logic [31:0] pl);
        packet_t p;
        p.valid   = 1'b1;
        p.leaf    = 5'(leaf);
        p.port    = 4'(port);
        p.seq     = 7'(sq);
        p.payload = pl;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        din = '0; vld = '0; cfg_we = 0; cfg_port = '0; cfg_dest = '0;
        upd_vld = 0; upd_port = '0; resend = 0; dout_rdy = 0;
        rst_n = 0;
        repeat (3) tick();
        rst_n = 1;
        rxq.delete();
    endtask

    task automatic cfg(input int port, input int leaf, input int dport);
        cfg_we = 1; cfg_port = 4'(port); cfg_dest = {5'(leaf), 4'(dport)};
        tick();
        cfg_we = 0;
    endtask

    task automatic upd(input int port);
        upd_vld = 1; upd_port = 4'(port);
        tick();
        upd_vld = 0;
    endtask

    task automatic push_word(input int k, input logic [31:0] data);
        logic got;
        got = 0;
        din[k*PW +: PW] = data;
        vld[k] = 1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = ack[k];
            tick();
        end
        vld[k] = 0;
        check("push_acked", got, 1);
    endtask

    task automatic wait_pkts(input int n, input int budget);
        for (int i = 0; i < budget && rxq.size() < n; i++) tick();
        repeat (4) tick();
        check("pkt_count", rxq.size(), n);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic acc;
        logic got;
        int   fval;
        int   ports [3];
        int   leafs [3];
        int   dps [3];
        ports = '{1, 4, 7};
        leafs = '{3, 1, 2};
        dps   = '{2, 4, 7};

        // 1: reset values, single word latency and one-cycle valid
        do_reset();
        @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_ack", ack, 0);
        vld = '1;
        #1;
        check("rst_fifos_empty", ack, 7'h7F);
        vld = '0;
        tick();
        cfg(1, 3, 2);
        upd(1);
        dout_rdy = 1;
        push_word(0, 32'hDEADBEEF);
        @(negedge clk);
        check("t1_n1_idle", dout, 0);
        tick();
        @(negedge clk);
        check("t1_pkt", dout, pkt(3, 2, 0, 32'hDEADBEEF));
        tick();
        @(negedge clk);
        check("t1_one_cycle", dout, 0);
        check("t1_credit", u_dut.credit[0], 63);

        // 2: round robin across ports 1, 4, 7
        do_reset();
        dout_rdy = 1;
        resend = 1;
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 3; i++)
                push_word(ports[p] - 1, 32'h2000_0000 | (ports[p] << 8) | i);
        for (int p = 0; p < 3; p++) cfg(ports[p], leafs[p], dps[p]);
        for (int p = 0; p < 3; p++) upd(ports[p]);
        resend = 0;
        wait_pkts(9, 60);
        for (int j = 0; j < 9 && j < rxq.size(); j++)
            check("t2_order", rxq[j], pkt(leafs[j%3], dps[j%3], j/3, 32'h2000_0000 | (ports[j%3] << 8) | (j/3)));

        // 3: no credit: FIFO fills, ack drops, nothing sent until an update
        do_reset();
        dout_rdy = 1;
        cfg(2, 4, 9);
        vld[1] = 1;
        for (int i = 0; i < 5; i++) begin
            din[1*PW +: PW] = 32'hA0 + i;
            @(negedge clk);
            check("t3_ack", ack[1], (i < 4));
            tick();
        end
        repeat (10) tick();
        check("t3_no_pkt", rxq.size(), 0);
        check("t3_ack_low", ack[1], 0);
        upd(2);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = ack[1];
            tick();
        end
        vld[1] = 0;
        check("t3_fifth_acked", got, 1);
        wait_pkts(5, 40);
        for (int i = 0; i < 5 && i < rxq.size(); i++)
            check("t3_pkt", rxq[i], pkt(4, 9, i, 32'hA0 + i));

        // 4: resend hold
        do_reset();
        cfg(1, 3, 2);
        upd(1);
        push_word(0, 32'hAAAA0001);
        push_word(0, 32'hAAAA0002);
        repeat (3) tick();
        @(negedge clk);
        check("t4_held", dout, pkt(3, 2, 0, 32'hAAAA0001));
        tick();
        resend = 1;
        dout_rdy = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_resend_zero", dout, 0);
            tick();
        end
        resend = 0;
        @(negedge clk);
        check("t4_reappear", dout, pkt(3, 2, 0, 32'hAAAA0001));
        tick();
        @(negedge clk);
        check("t4_next_seq", dout, pkt(3, 2, 1, 32'hAAAA0002));
        repeat (3) tick();
        check("t4_count", rxq.size(), 2);

        // 5: dout_rdy low holds the packet and the FIFO
        do_reset();
        cfg(1, 3, 2);
        upd(1);
        push_word(0, 32'hC0);
        push_word(0, 32'hD0);
        push_word(0, 32'hE0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_stable", dout, pkt(3, 2, 0, 32'hC0));
            check("t5_fifo_count", u_dut.g_port[0].u_fifo.count, 2);
            tick();
        end
        dout_rdy = 1;
        wait_pkts(3, 20);
        if (rxq.size() == 3) begin
            check("t5_c", rxq[0], pkt(3, 2, 0, 32'hC0));
            check("t5_d", rxq[1], pkt(3, 2, 1, 32'hD0));
            check("t5_e", rxq[2], pkt(3, 2, 2, 32'hE0));
        end

        // 6: credit saturation, exhaustion, netting and sequence wrap
        do_reset();
        dout_rdy = 1;
        fval = 0;
        din[0 +: PW] = 32'(fval);
        vld[0] = 1;
        cfg_port = 4'd1;
        cfg_dest = {5'd3, 4'd2};
        upd_port = 4'd1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            upd_vld = (cyc < 3);
            cfg_we  = (cyc == 3);
            @(negedge clk);
            acc = ack[0];
            tick();
            if (acc) begin
                fval++;
                din[0 +: PW] = 32'(fval);
            end
        end
        upd_vld = 0;
        cfg_we = 0;
        check("t6_sat_count", rxq.size(), 128);
        for (int i = 0; i < 128 && i < rxq.size(); i++)
            check("t6_pkt_a", rxq[i], pkt(3, 2, i % 128, 32'(i)));
        for (int cyc = 0; cyc < 300; cyc++) begin
            upd_vld = (cyc == 0 || cyc == 10);
            @(negedge clk);
            acc = ack[0];
            tick();
            if (acc) begin
                fval++;
                din[0 +: PW] = 32'(fval);
            end
        end
        upd_vld = 0;
        vld[0] = 0;
        check("t6_net_count", rxq.size(), 256);
        for (int i = 128; i < 256 && i < rxq.size(); i++)
            check("t6_pkt_b", rxq[i], pkt(3, 2, i % 128, 32'(i)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/leaf_tx_packetizer.md
Name: leaf_tx_packetizer

Overview:
Parametrised transmit path for a BFT leaf: NUM_OUT_PORTS user output streams (valid/ack) are buffered, round-robin arbitrated and packed into PACKET_BITS-wide BFT packets.
- Per-port credit counters are replenished by freespace updates from the destination; a port sends only while it holds credit.
- Sits between user_kernel outputs and the leaf's dout_leaf_interface2bft, in the 400 MHz domain.
- Adds per-port sequence tagging and resend hold, which the fixed 7-port shell does not have.

Parameters:
PACKET_BITS, 49, packet width; must equal 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS
PAYLOAD_BITS, 32, user data width
NUM_LEAF_BITS, 5, destination leaf field width
NUM_PORT_BITS, 4, destination port field width
NUM_ADDR_BITS, 7, sequence field width
NUM_OUT_PORTS, 7, user output ports, 1..2^NUM_PORT_BITS-1
FIFO_DEPTH, 4, per-port buffer depth, power of two >= 2
FREESPACE_UPDATE_SIZE, 64, credits added per update
MAX_CREDIT, 128, credit saturation value

Ports:
clk_400  in  1  clock
reset_n_400  in  1  asynchronous, active-low reset
din_user2tx  in  NUM_OUT_PORTS*PAYLOAD_BITS  user data; port k occupies slice k-1
vld_user2tx  in  NUM_OUT_PORTS  per-port valid
ack_tx2user  out  NUM_OUT_PORTS  per-port accept
cfg_we  in  1  route-table write strobe
cfg_port  in  NUM_PORT_BITS  port index written, 1-based
cfg_dest  in  NUM_LEAF_BITS+NUM_PORT_BITS  {dest leaf, dest port}
upd_vld  in  1  freespace update strobe
upd_port  in  NUM_PORT_BITS  port credited, 1-based
resend  in  1  hold; output suppressed
dout_tx2bft  out  PACKET_BITS  packet, bit MSB = valid
dout_rdy  in  1  BFT accepts packet this cycle

Behaviour:
- Reset (async assert, sync deassert by the caller): ack_tx2user=0, dout_tx2bft=0, FIFOs empty, credits=0, sequence counters=0, route table=0, RR pointer=port 1.
- User side: ack_tx2user[k] = vld_user2tx[k] & FIFO k not full. A word is written when both are high. The ack is combinational from FIFO state only, never from downstream.
- Arbiter: eligible[k] = FIFO k not empty & credit[k]>0 & route[k] written since reset. Round-robin starts at the port after the last winner and wraps from NUM_OUT_PORTS to 1. One grant per cycle.
- Output register stage. When the output register is empty, or holds a valid packet and dout_rdy=1 and resend=0, the register loads the winner: {1'b1, dest_leaf, dest_port, seq[k], payload}. The same cycle pops FIFO k, decrements credit[k] and increments seq[k].
- If no port is eligible, the register loads all zeros.
- Latency: user write in cycle N reaches dout at the earliest in cycle N+2.
- seq wraps modulo 2^NUM_ADDR_BITS.
- resend=1: dout_tx2bft forced to 0 combinationally. The register holds its contents, with no pop, no credit change and no RR advance. The held packet reappears when resend drops.
- dout_rdy=0 with a valid packet: hold the packet stable, no pop.
- Credits: upd_vld adds FREESPACE_UPDATE_SIZE to credit[upd_port], saturating at MAX_CREDIT. A simultaneous update and send on the same port nets both (+SIZE−1, then saturate).
- upd_port or cfg_port equal to 0 or greater than NUM_OUT_PORTS: ignored.
- Write while full is impossible because ack=0. A FIFO that is simultaneously written and popped keeps its count.
- cfg_we to a port with a packet in flight takes effect on the next grant only.

Decomposition:
- Package leaf_tx_pkg: packet field offsets/widths derived from the parameters, a valid-bit index constant, and the packet struct/typedef.
- One sub-module: leaf_tx_fifo, a single-clock FIFO with FIFO_DEPTH entries and full/empty/count, instantiated NUM_OUT_PORTS times.
- Arbiter and credit logic stay inline.

Test Plan:
1. Reset, cfg port1→{leaf 3, port 2}, one upd on port 1, dout_rdy=1, port1 sends 0xDEADBEEF → two cycles later dout = {1,5'd3,4'd2,7'd0,32'hDEADBEEF} for one cycle; credit[1]=63.
2. Ports 1, 4 and 7 configured and credited, each with 3 words queued, dout_rdy=1 → output order 1,4,7,1,4,7,1,4,7; seq per port 0,1,2.
3. No upd on port 2, 5 words written → ack drops after FIFO_DEPTH (4) words and no packet appears. A single upd then produces 4 packets, and the 5th word is accepted afterwards.
4. resend pulsed high for 3 cycles while a valid packet is held → dout=0 during the pulse, and the identical packet appears afterwards. No sequence number is skipped.
5. dout_rdy held low for 10 cycles → dout is stable and the FIFO count is unchanged. Transfers resume on the rdy=1 edge.
6. Port 1 starts with 100 credits; upd and grant on port 1 in the same cycle → credit=MAX_CREDIT (128), saturated. 129 sends without further updates → the 129th packet is not sent.
